// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED refresh sequencer:
//   - state_t   : sequencer FSM states
//   - INIT_LEN  : number of power-up command bytes
//   - WIN_LEN   : number of window-setup command bytes sent before each frame
//   - init_cmd(), win_cmd() : command byte tables, indexed from 0
// Build option: OLED_SEQ_INVERT_EN adds a leading display-invert command
// (A6 normal / A7 inverted) to the window setup, making it 7 bytes long.
// -----------------------------------------------------------------------------
package oled_pkg;

  typedef enum logic [2:0] {
    PANEL_RST,
    INIT,
    IDLE,
    SET_WIN,
    FETCH,
    SEND
  } state_t;

  localparam int IDX_W    = 4;
  localparam int INIT_LEN = 11;
`ifdef OLED_SEQ_INVERT_EN
  localparam int WIN_LEN  = 7;
`else
  localparam int WIN_LEN  = 6;
`endif

  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(INIT_LEN - 1);
  localparam logic [IDX_W-1:0] WIN_LAST  = IDX_W'(WIN_LEN - 1);

  localparam logic [7:0] CMD_NORMAL = 8'hA6;
  localparam logic [7:0] CMD_INVERT = 8'hA7;

  // Power-up sequence: display off, charge pump on, horizontal addressing,
  // contrast, pre-charge, resume from RAM, display on.
  function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    init_cmd = 8'hAE;
      4'd1:    init_cmd = 8'h8D;
      4'd2:    init_cmd = 8'h14;
      4'd3:    init_cmd = 8'h20;
      4'd4:    init_cmd = 8'h00;
      4'd5:    init_cmd = 8'h81;
      4'd6:    init_cmd = 8'hCF;
      4'd7:    init_cmd = 8'hD9;
      4'd8:    init_cmd = 8'hF1;
      4'd9:    init_cmd = 8'hA4;
      4'd10:   init_cmd = 8'hAF;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  // Window setup: column range 0..127, page range 0..7.
  function automatic logic [7:0] win_cmd(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    win_cmd = 8'h21;
      4'd1:    win_cmd = 8'h00;
      4'd2:    win_cmd = 8'h7F;
      4'd3:    win_cmd = 8'h22;
      4'd4:    win_cmd = 8'h00;
      4'd5:    win_cmd = 8'h07;
      default: win_cmd = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/oled_cmd_rom.sv
// -----------------------------------------------------------------------------
// oled_cmd_rom
// Combinational command-byte lookup for the OLED sequencer.
// Ports:
//   i_win     in  1  0 = power-up sequence, 1 = window-setup sequence
//   i_idx     in  4  byte index within the selected sequence
//   i_invert  in  1  (only with OLED_SEQ_INVERT_EN) selects A7/A6 at index 0
//   o_byte    out 8  command byte; 00 for indices past the end
// Build option: OLED_SEQ_INVERT_EN.
// -----------------------------------------------------------------------------
module oled_cmd_rom
  import oled_pkg::*;
(
  input  logic             i_win,
  input  logic [IDX_W-1:0] i_idx,
`ifdef OLED_SEQ_INVERT_EN
  input  logic             i_invert,
`endif
  output logic [7:0]       o_byte
);

  always_comb begin
    // NOTE: assign a default first so no path leaves o_byte unassigned,
    // otherwise synthesis infers a latch.
    o_byte = 8'h00;
    if (!i_win) begin
      o_byte = init_cmd(i_idx);
    end else begin
`ifdef OLED_SEQ_INVERT_EN
      // Invert command leads the window setup; the rest shifts by one.
      if (i_idx == '0) begin
        o_byte = i_invert ? CMD_INVERT : CMD_NORMAL;
      end else begin
        o_byte = win_cmd(i_idx - 1'b1);
      end
`else
      o_byte = win_cmd(i_idx);
`endif
    end
  end

endmodule

// File: rtl/oled_seq.sv
// -----------------------------------------------------------------------------
// oled_seq
// OLED panel sequencer: panel reset, power-up command sequence, then on each
// frame request a window setup followed by a full framebuffer stream to an
// SPI byte shifter (valid/ready handshake).
// Parameters:
//   RST_HOLD  cycles oled_rst_n is held low after reset release (>= 1)
//   FB_BYTES  data bytes per frame (128 columns x 8 pages = 1024)
// Ports:
//   clk, rst          clock (posedge), asynchronous active-high reset
//   frame_req   in    one-cycle frame refresh request (merged, one-deep)
//   fb_addr     out   framebuffer read address {page[2:0], col[6:0]}
//   fb_data     in    framebuffer byte, valid one cycle after fb_addr
//   tx_valid    out   byte offered to shifter
//   tx_ready    in    shifter accepts this cycle
//   tx_byte     out   byte to shift, MSB first
//   tx_dc       out   D/C line: 0 command, 1 data
//   oled_rst_n  out   panel reset, active-low
//   init_done   out   power-up sequence complete
//   busy        out   frame in progress
//   frame_done  out   one-cycle pulse after the last data byte is accepted
//   invert      in    (only with OLED_SEQ_INVERT_EN) display inversion,
//                     sampled when a frame starts
// Build option: OLED_SEQ_INVERT_EN.
// -----------------------------------------------------------------------------
module oled_seq
  import oled_pkg::*;
#(
  parameter int RST_HOLD = 16,
  parameter int FB_BYTES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_req,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_dc,
  output logic       oled_rst_n,
  output logic       init_done,
  output logic       busy,
  output logic       frame_done
`ifdef OLED_SEQ_INVERT_EN
  ,
  input  logic       invert
`endif
);

  localparam int               HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
  localparam logic [9:0]       ADDR_LAST = 10'(FB_BYTES - 1);

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_pending;
  logic              r_loaded;   // SEND has captured fb_data into tx_byte

  logic              w_xfer;
  logic              w_rom_win;
  logic [IDX_W-1:0]  w_rom_idx;
  logic [7:0]        w_rom_byte;

  assign w_xfer = tx_valid & tx_ready;

  // The ROM is addressed with the index of the byte to load next, so the
  // registered tx_byte is ready the cycle the state is entered or advanced.
  assign w_rom_win = (r_state == IDLE) || (r_state == SET_WIN);
  assign w_rom_idx = ((r_state == PANEL_RST) || (r_state == IDLE)) ? '0
                                                                   : r_idx + 1'b1;

  oled_cmd_rom u_cmd_rom (
    .i_win    (w_rom_win),
    .i_idx    (w_rom_idx),
`ifdef OLED_SEQ_INVERT_EN
    .i_invert (invert),
`endif
    .o_byte   (w_rom_byte)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would create order-dependent
  // races between the FSM and its outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PANEL_RST;
      r_hold_cnt <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_loaded   <= 1'b0;
      oled_rst_n <= 1'b0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
      tx_dc      <= 1'b0;
      fb_addr    <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // One-deep request latch. A new request in the same cycle the pending
      // one is consumed must survive, so setting takes priority over clearing.
      if (frame_req) begin
        r_pending <= 1'b1;
      end else if ((r_state == IDLE) && r_pending) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        PANEL_RST: begin
          if (r_hold_cnt == HOLD_LAST) begin
            oled_rst_n <= 1'b1;
            r_state    <= INIT;
            r_idx      <= '0;
            tx_valid   <= 1'b1;
            tx_byte    <= w_rom_byte;
            tx_dc      <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        INIT: begin
          if (w_xfer) begin
            if (r_idx == INIT_LAST) begin
              tx_valid  <= 1'b0;
              init_done <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              tx_byte <= w_rom_byte;
            end
          end
        end

        IDLE: begin
          if (r_pending) begin
            r_state  <= SET_WIN;
            busy     <= 1'b1;
            r_idx    <= '0;
            fb_addr  <= '0;
            tx_valid <= 1'b1;
            tx_byte  <= w_rom_byte;
            tx_dc    <= 1'b0;
          end
        end

        SET_WIN: begin
          if (w_xfer) begin
            if (r_idx == WIN_LAST) begin
              tx_valid <= 1'b0;
              r_state  <= FETCH;
            end else begin
              r_idx   <= r_idx + 1'b1;
              tx_byte <= w_rom_byte;
            end
          end
        end

        // fb_addr is already stable here; the framebuffer answers next cycle.
        FETCH: begin
          r_loaded <= 1'b0;
          r_state  <= SEND;
        end

        // First SEND cycle captures the read data, then offers it until taken.
        SEND: begin
          if (!r_loaded) begin
            tx_byte  <= fb_data;
            tx_dc    <= 1'b1;
            tx_valid <= 1'b1;
            r_loaded <= 1'b1;
          end else if (w_xfer) begin
            tx_valid <= 1'b0;
            if (fb_addr == ADDR_LAST) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              r_state    <= IDLE;
            end else begin
              fb_addr <= fb_addr + 1'b1;
              r_state <= FETCH;
            end
          end
        end

        default: r_state <= PANEL_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_seq.sv
// -----------------------------------------------------------------------------
// tb_oled_seq
// Self-checking bench for oled_seq. A queue-based reference holds the byte
// stream the panel must receive (init table, window table, framebuffer
// contents); a negedge compare process pops it on every handshake and also
// checks busy / init_done / frame_done / hold stability each cycle. The main
// process runs directed scenarios; tx_ready and invert are randomized.
// Build option: OLED_SEQ_INVERT_EN (must match the RTL build).
// -----------------------------------------------------------------------------
module tb_oled_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_req;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       oled_rst_n;
  logic       init_done;
  logic       busy;
  logic       frame_done;
`ifdef OLED_SEQ_INVERT_EN
  logic       invert;
  localparam int WIN_N = 7;
`else
  localparam int WIN_N = 6;
`endif

  always #5 clk = ~clk;

  oled_seq #(.RST_HOLD(16), .FB_BYTES(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_req  (frame_req),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_byte    (tx_byte),
    .tx_dc      (tx_dc),
    .oled_rst_n (oled_rst_n),
    .init_done  (init_done),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef OLED_SEQ_INVERT_EN
    ,
    .invert     (invert)
`endif
  );

  // Synchronous-read framebuffer: data one cycle after the address.
  logic [7:0] fb_mem [1024];
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] b;
    logic       dc;
    logic       init_end;
    logic       frame_end;
    logic [9:0] idx;
  } item_t;

  item_t      m_q[$];
  logic [7:0] init_tbl [11] = '{8'hAE, 8'h8D, 8'h14, 8'h20, 8'h00, 8'h81,
                                8'hCF, 8'hD9, 8'hF1, 8'hA4, 8'hAF};
  logic [7:0] win_tbl  [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  int         n_data = 0;          // data bytes accepted in current frame
  int         n_frames_seen = 0;   // frame_done pulses observed
  logic [7:0] log_b  [2048];
  logic       log_dc [2048];
  int         n_log = 0;

  bit stall_force = 0;
  bit rand_mode   = 0;

  task automatic queue_init();
    for (int i = 0; i < 11; i++)
      m_q.push_back('{b: init_tbl[i], dc: 1'b0, init_end: (i == 10), frame_end: 1'b0, idx: 10'd0});
  endtask

  task automatic queue_frame();
`ifdef OLED_SEQ_INVERT_EN
    m_q.push_back('{b: (invert ? 8'hA7 : 8'hA6), dc: 1'b0, init_end: 1'b0, frame_end: 1'b0, idx: 10'd0});
`endif
    for (int i = 0; i < 6; i++)
      m_q.push_back('{b: win_tbl[i], dc: 1'b0, init_end: 1'b0, frame_end: 1'b0, idx: 10'd0});
    for (int i = 0; i < 1024; i++)
      m_q.push_back('{b: fb_mem[i], dc: 1'b1, init_end: 1'b0, frame_end: (i == 1023), idx: 10'(i)});
    n_data = 0;
  endtask

  // Compare process: each negedge checks flags, then applies what the
  // upcoming posedge does (frame start, request latch, handshake pop).
  initial begin : cmp
    bit         armed = 1;
    bit         m_idle = 0, m_pending = 0, m_busy = 0, m_init = 0, m_done = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_b;
    logic       prev_dc;
    item_t      it;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        armed = 1; m_idle = 0; m_pending = 0; m_busy = 0; m_init = 0; m_done = 0;
        prev_stall = 0;
        continue;
      end
      if (armed) begin
        queue_init();
        armed = 0;
      end
      if (frame_done) n_frames_seen++;
      check("init_done", init_done, m_init);
      check("busy", busy, m_busy);
      check("frame_done", frame_done, m_done);
      m_done = 0;
      if (!oled_rst_n) check("valid_in_panel_rst", tx_valid, 0);
      if (m_q.size() == 0) check("valid_when_idle", tx_valid, 0);
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_byte", tx_byte, prev_b);
        check("hold_dc", tx_dc, prev_dc);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_b     = tx_byte;
      prev_dc    = tx_dc;

      if (m_idle && m_pending) begin
        queue_frame();
        m_idle = 0; m_pending = 0; m_busy = 1;
      end
      if (frame_req) m_pending = 1;

      if (tx_valid && tx_ready) begin
        check("byte_expected", (m_q.size() != 0), 1);
        if (m_q.size() != 0) begin
          it = m_q.pop_front();
          check("tx_byte", tx_byte, it.b);
          check("tx_dc", tx_dc, it.dc);
          if (n_log < 2048) begin
            log_b[n_log]  = tx_byte;
            log_dc[n_log] = tx_dc;
            n_log++;
          end
          if (it.dc) begin
            check("fb_addr", fb_addr, it.idx);
            n_data++;
          end
          if (it.init_end) begin m_init = 1; m_idle = 1; end
          if (it.frame_end) begin m_busy = 0; m_done = 1; m_idle = 1; end
        end
      end
    end
  end

  // Input driver for tx_ready / invert, updated after each posedge.
  initial begin : drv
    tx_ready = 1'b1;
`ifdef OLED_SEQ_INVERT_EN
    invert = 1'b0;
`endif
    forever begin
      @(posedge clk); #2;
      if (stall_force)    tx_ready = 1'b0;
      else if (rand_mode) tx_ready = ($urandom_range(0, 3) != 0);
      else                tx_ready = 1'b1;
`ifdef OLED_SEQ_INVERT_EN
      invert = 1'($urandom_range(0, 1));
`endif
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  task automatic pulse_req(input int cycles);
    frame_req = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    frame_req = 1'b0;
  endtask

  // Releases rst (caller is at posedge+#1) and counts edges oled_rst_n stays low.
  task automatic release_and_count(input bit req_during_rst);
    int k = 0;
    rst = 1'b0;
    if (req_during_rst) frame_req = 1'b1;
    do begin
      @(posedge clk); #1;
      frame_req = 1'b0;
      k++;
    end while (!oled_rst_n && k < 100);
    check("rst_hold_cycles", k - 1, 16);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 200) begin @(posedge clk); #1; n++; end
    check("init_done_reached", init_done, 1);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (n_frames_seen < target && n < 12000) begin @(posedge clk); #1; n++; end
    check("frames_reached", n_frames_seen, target);
  endtask

  task automatic wait_data(input int target);
    int n = 0;
    while (n_data < target && n < 12000) begin @(posedge clk); #1; n++; end
    check("data_reached", (n_data >= target), 1);
  endtask

  initial begin : main
    int exp_idx;
    int d0;
    rst = 1'b1;
    frame_req = 1'b0;
    for (int i = 0; i < 1024; i++) fb_mem[i] = 8'(i);

    repeat (3) @(negedge clk);
    check("rst_oled_rst_n", oled_rst_n, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    check("rst_fb_addr", fb_addr, 0);

    // Panel reset, with a request held across PANEL_RST/INIT.
    @(posedge clk); #1;
    release_and_count(1'b1);
    wait_init();

    // First frame (tx_ready=1): three merged requests mid-frame -> one more.
    wait_data(100);
    pulse_req(1); repeat (20) @(posedge clk); #1;
    pulse_req(1); repeat (20) @(posedge clk); #1;
    pulse_req(1);
    wait_frames(1);
    wait_frames(2);
    repeat (50) @(posedge clk); #1;
    check("frames_after_merge", n_frames_seen, 2);
    check("idle_after_merge", busy, 0);

    // Literal pins of the logged stream.
    d0 = 11 + WIN_N;
    check("log_init0", log_b[0], 8'hAE);
    check("log_init10", log_b[10], 8'hAF);
    check("log_init_dc", log_dc[5], 0);
    check("log_win_first", log_b[d0 - 6], 8'h21);
    check("log_win_last", log_b[d0 - 1], 8'h07);
    check("log_data0", log_b[d0], 8'h00);
    check("log_data255", log_b[d0 + 255], 8'hFF);
    check("log_data256", log_b[d0 + 256], 8'h00);
    check("log_data1023", log_b[d0 + 1023], 8'hFF);
    check("log_data_dc", log_dc[d0 + 7], 1);

    // Random data, random tx_ready; two-cycle request hits IDLE->SET_WIN.
    for (int i = 0; i < 1024; i++) fb_mem[i] = 8'($urandom);
    rand_mode = 1;
    pulse_req(2);

    // Forced 5-cycle stall while a data byte is offered.
    begin
      int n = 0;
      while (!(tx_valid && tx_dc && n_data >= 50) && n < 12000) begin
        @(posedge clk); #1; n++;
      end
    end
    check("stall_point_reached", (tx_valid && tx_dc), 1);
    stall_force = 1;
    exp_idx = n_data;
    repeat (5) begin
      @(negedge clk);
      check("stall_fb_addr", fb_addr, 10'(exp_idx));
      check("stall_byte", tx_byte, fb_mem[exp_idx]);
      check("stall_dc", tx_dc, 1);
    end
    @(posedge clk); #1;
    stall_force = 0;

    wait_frames(3);
    wait_frames(4);
    repeat (50) @(posedge clk); #1;
    check("frames_after_double_req", n_frames_seen, 4);

    // Reset at data byte 300 with another request pending.
    pulse_req(1);
    wait_data(100);
    pulse_req(1);
    wait_data(300);
    rst = 1'b1;
    #1;
    check("mid_rst_oled_rst_n", oled_rst_n, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_byte", tx_byte, 8'h00);
    check("mid_rst_tx_dc", tx_dc, 0);
    check("mid_rst_fb_addr", fb_addr, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    repeat (3) @(posedge clk); #1;
    release_and_count(1'b0);
    wait_init();
    repeat (300) @(posedge clk); #1;
    check("no_frame_after_rst", busy, 0);
    check("frames_after_rst", n_frames_seen, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oled_seq.md
OLED_SEQ -- requirements
Module: oled_seq

Interface
REQ-001 SHALL have parameter RST_HOLD, default 16, meaning cycles oled_rst_n is held low after reset release.
REQ-002 SHALL have parameter FB_BYTES, default 1024, meaning data bytes per frame (128 columns x 8 pages).
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port frame_req  in  1  one-cycle pulse requesting a full-frame refresh.
REQ-006 SHALL have port fb_addr  out  10  framebuffer read address, {page[2:0], col[6:0]}.
REQ-007 SHALL have port fb_data  in  8  framebuffer byte, valid exactly one cycle after fb_addr.
REQ-008 SHALL have port tx_valid  out  1  byte offered to the SPI byte shifter.
REQ-009 SHALL have port tx_ready  in  1  shifter accepts the byte this cycle.
REQ-010 SHALL have port tx_byte  out  8  byte to shift, MSB first.
REQ-011 SHALL have port tx_dc  out  1  OLED D/C line: 0 command, 1 data.
REQ-012 SHALL have port oled_rst_n  out  1  OLED panel reset, active-low.
REQ-013 SHALL have ports init_done, busy, frame_done  out  1 each: init complete; frame in progress; one-cycle pulse at last data byte accepted.

Function
REQ-014 A byte SHALL transfer only on a cycle with tx_valid & tx_ready; tx_byte and tx_dc SHALL stay stable while tx_valid & ~tx_ready.
REQ-015 FSM states SHALL be PANEL_RST, INIT, IDLE, SET_WIN, FETCH, SEND.
REQ-016 PANEL_RST: oled_rst_n=0 for RST_HOLD cycles, then 1 and go to INIT.
REQ-017 INIT SHALL send, tx_dc=0, in order: AE 8D 14 20 00 81 CF D9 F1 A4 AF (11 bytes); after the 11th accept, init_done=1 and go to IDLE.
REQ-018 IDLE: with pending request, go to SET_WIN next cycle and set busy=1.
REQ-019 SET_WIN SHALL send, tx_dc=0: 21 00 7F 22 00 07 (6 bytes), then go to FETCH with address 0.
REQ-020 FETCH SHALL drive fb_addr for one cycle with tx_valid=0; SEND SHALL capture fb_data and offer it with tx_dc=1 until accepted.
REQ-021 On SEND accept, address SHALL increment; at FB_BYTES-1 accept: frame_done pulse, busy=0, go to IDLE; else go to FETCH.
REQ-022 fb_addr SHALL not wrap within a frame; it SHALL reset to 0 at each SET_WIN.
REQ-023 frame_req SHALL set a one-deep pending flag in any state; extra requests while pending SHALL be merged.
REQ-024 Pending flag SHALL clear on IDLE->SET_WIN; frame_req in that same cycle SHALL re-set it.
REQ-025 A request arriving before init_done SHALL be held and served immediately after INIT.
REQ-026 tx_valid SHALL be 0 in PANEL_RST, IDLE and FETCH.

Reset
REQ-027 While rst=1, asynchronously: state=PANEL_RST, hold counter=0, oled_rst_n=0, tx_valid=0, tx_byte=00, tx_dc=0, fb_addr=0, init_done=0, busy=0, frame_done=0, pending=0.
REQ-028 Reset mid-frame or mid-init SHALL abort the transfer; full panel reset and INIT SHALL rerun.

Configuration
REQ-029 Macro OLED_SEQ_INVERT_EN SHALL add input port invert (1 bit).
REQ-030 With OLED_SEQ_INVERT_EN, SET_WIN SHALL prepend A7 (invert=1) or A6 (invert=0), making 7 command bytes; invert sampled on IDLE->SET_WIN.
REQ-031 Without OLED_SEQ_INVERT_EN, no invert port and SET_WIN SHALL send exactly 6 bytes.

Structure
REQ-032 Shared package oled_pkg SHALL hold the state enum, init/window command byte constants, INIT_LEN=11 and WIN_LEN.
REQ-033 Combinational sub-module oled_cmd_rom SHALL map (phase, index) to command byte; FSM, counters and handshake stay in oled_seq.

Verification
REQ-034 Release rst, tx_ready=1 -> oled_rst_n low exactly 16 cycles, then 11 bytes AE..AF with tx_dc=0, init_done=1.
REQ-035 frame_req after init, fb_data=fb_addr[7:0], tx_ready=1 -> 21 00 7F 22 00 07 then 1024 data bytes 00..FF repeating, tx_dc=1, frame_done once.
REQ-036 tx_ready low 5 cycles during SEND -> tx_byte/tx_dc unchanged, fb_addr not advanced, no byte lost or duplicated.
REQ-037 Three frame_req pulses during a frame -> exactly one further frame; pulse in IDLE->SET_WIN cycle -> one additional frame.
REQ-038 rst asserted at data byte 300 -> all outputs at reset values same cycle; after release full PANEL_RST and INIT rerun, pending=0.
REQ-039 With OLED_SEQ_INVERT_EN, invert=1 at request -> A7 precedes 21 00 7F 22 00 07; invert=0 -> A6.
